keccak_arbiter: RTL and testbench

KECCAK_ARBITER -- requirements
Module: keccak_arbiter

---
 rtl/keccak_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/keccak_arbiter.sv | 164 ++++++++++++++++
 tb/tb_keccak_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
// Shared definitions for the keccak core front-end arbiter:
//   W                      - data word width of the core interface
//   HDR_IN_LEN_LSB/MSB     - position of in_len (bits) inside the header word
//   HDR_OUT_LEN_LSB/MSB    - position of out_len (bits) inside the header word
//   arb_state_t            - arbiter job FSM states
//   len_to_words()         - bit length -> number of W-bit words (ceiling)
// -----------------------------------------------------------------------------
package keccak_pkg;

    localparam int W               = 64;
    localparam int W_SHIFT         = $clog2(W);

    localparam int HDR_IN_LEN_LSB  = 0;
    localparam int HDR_IN_LEN_MSB  = 31;
    localparam int HDR_OUT_LEN_LSB = 32;
    localparam int HDR_OUT_LEN_MSB = 63;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_ABSORB  = 2'd2,
        ST_SQUEEZE = 2'd3
    } arb_state_t;

    // Ceiling of len / W. The addition is done in 33 bits so a length near
    // 2^32 does not wrap before the shift.
    function automatic logic [31:0] len_to_words(input logic [31:0] len);
        logic [32:0] sum;
        sum = {1'b0, len} + 33'(W - 1);
        return 32'(sum >> W_SHIFT);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first set bit of req, searching
// cyclically starting at last_gnt+1.
// Ports:
//   req      in  NUM_REQ  request vector
//   last_gnt in  IW       index granted most recently
//   winner   out IW       selected requester (0 when any = 0)
//   any      out 1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter
    import keccak_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_gnt,
    output logic [IW-1:0]      winner,
    output logic               any
);

    logic [IW:0]        shamt;
    logic [NUM_REQ-1:0] rot;
    int                 pos;

    // Rotating the doubled vector right by last_gnt+1 puts the highest
    // priority requester at bit 0.
    assign shamt = {1'b0, last_gnt} + (IW+1)'(1);

    always_comb begin
        rot    = NUM_REQ'({req, req} >> shamt);
        pos    = 0;
        any    = 1'b0;
        // Scan downwards so the lowest rotated position wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = int'(last_gnt) + 1 + i;
                any = 1'b1;
            end
        end
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end
        winner = IW'(pos);
    end

endmodule

// File: rtl/keccak_arbiter.sv
// -----------------------------------------------------------------------------
// keccak_arbiter
// Shares one keccak core between NUM_REQ requesters. A job is one header
// word, ceil(in_len/W) message words and max(1, ceil(out_len/W)) output
// words; the owner keeps the core for the whole job.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid/req_data/      per-requester input word stream
//   req_ready
//   rsp_valid/rsp_ready      per-requester output handshake
//   rsp_data                 output word, shared by all requesters
//   core_valid_in_n/         core input side (valid active-low)
//   core_data_in/
//   core_ready_out
//   core_ready_in_n/         core output side (ready active-low)
//   core_valid_out/
//   core_data_out
//   busy, gnt_id             job in progress and its owner
// -----------------------------------------------------------------------------
module keccak_arbiter
    import keccak_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic                 core_valid_in_n,
    output logic [W-1:0]         core_data_in,
    input  logic                 core_ready_out,
    output logic                 core_ready_in_n,
    input  logic                 core_valid_out,
    input  logic [W-1:0]         core_data_out,
    output logic                 busy,
    output logic [IW-1:0]        gnt_id
);

    arb_state_t    state;
    logic [IW-1:0] last_gnt;
    logic [31:0]   in_cnt;
    logic [31:0]   out_cnt;

    logic [W-1:0]  req_words [NUM_REQ];
    logic [IW-1:0] arb_winner;
    logic          arb_any;

    logic          in_phase;
    logic          out_phase;
    logic          sel_valid;
    logic          sel_rsp_ready;
    logic [W-1:0]  sel_data;
    logic          in_xfer;
    logic          out_xfer;
    logic [31:0]   hdr_in_words;
    logic [31:0]   hdr_out_words;
    logic [31:0]   out_load;

    genvar gi;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_words[gi] = req_data[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .winner   (arb_winner),
        .any      (arb_any)
    );

    assign in_phase      = (state == ST_HEADER) || (state == ST_ABSORB);
    assign out_phase     = (state == ST_SQUEEZE);

    assign sel_valid     = req_valid[gnt_id];
    assign sel_rsp_ready = rsp_ready[gnt_id];
    assign sel_data      = req_words[gnt_id];

    // Handshake outputs are pure gating of the registered state, so they
    // fall to their idle values the moment reset forces the FSM to IDLE.
    assign core_valid_in_n = in_phase  ? !sel_valid     : 1'b1;
    assign core_data_in    = in_phase  ? sel_data       : '0;
    assign core_ready_in_n = out_phase ? !sel_rsp_ready : 1'b1;
    assign rsp_data        = out_phase ? core_data_out  : '0;

    assign in_xfer  = in_phase  && sel_valid      && core_ready_out;
    assign out_xfer = out_phase && core_valid_out && sel_rsp_ready;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_route
            logic owner;
            assign owner         = busy && (gnt_id == IW'(gi));
            assign req_ready[gi] = owner && in_phase  && core_ready_out;
            assign rsp_valid[gi] = owner && out_phase && core_valid_out;
        end
    endgenerate

    // Header decode, only meaningful during the HEADER transfer.
    assign hdr_in_words  = len_to_words(sel_data[HDR_IN_LEN_MSB:HDR_IN_LEN_LSB]);
    assign hdr_out_words = len_to_words(sel_data[HDR_OUT_LEN_MSB:HDR_OUT_LEN_LSB]);
    // A zero output length still produces one squeeze word.
    assign out_load      = (hdr_out_words == 32'd0) ? 32'd1 : hdr_out_words;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            gnt_id   <= '0;
            last_gnt <= IW'(NUM_REQ - 1);
            in_cnt   <= '0;
            out_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_id   <= arb_winner;
                        last_gnt <= arb_winner;
                        busy     <= 1'b1;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (in_xfer) begin
                        in_cnt  <= hdr_in_words;
                        out_cnt <= out_load;
                        state   <= (hdr_in_words == 32'd0) ? ST_SQUEEZE : ST_ABSORB;
                    end
                end
                ST_ABSORB: begin
                    if (in_xfer) begin
                        in_cnt <= in_cnt - 32'd1;
                        if (in_cnt == 32'd1) begin
                            state <= ST_SQUEEZE;
                        end
                    end
                end
                ST_SQUEEZE: begin
                    if (out_xfer) begin
                        out_cnt <= out_cnt - 32'd1;
                        // Completion returns to IDLE; arbitration happens
                        // there on the following cycle.
                        if (out_cnt == 32'd1) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keccak_arbiter
// Directed jobs from two requesters against a simple core model whose output
// words are BASE + running handshake count. Expected input and output words
// are queued when a job is issued; a monitor pops them as transfers happen.
// -----------------------------------------------------------------------------
module tb_keccak_arbiter;
    import keccak_pkg::*;

    localparam int          N    = 2;
    localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

    typedef logic [0:0] rid_t;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] data;
    } xact_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           core_valid_in_n;
    logic [W-1:0]   core_data_in;
    logic           core_ready_out;
    logic           core_ready_in_n;
    logic           core_valid_out;
    logic [W-1:0]   core_data_out;
    logic           busy;
    logic [0:0]     gnt_id;

    logic           rv [N];
    logic [W-1:0]   rd [N];

    xact_t in_q[$];
    xact_t out_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    exp_seq     = 0;
    bit    stall_mode  = 1'b0;
    logic [31:0] seq;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_valid[gi]         = rv[gi];
            assign req_data[gi*W +: W]   = rd[gi];
        end
    endgenerate

    keccak_arbiter #(.NUM_REQ(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .core_valid_in_n (core_valid_in_n),
        .core_data_in    (core_data_in),
        .core_ready_out  (core_ready_out),
        .core_ready_in_n (core_ready_in_n),
        .core_valid_out  (core_valid_out),
        .core_data_out   (core_data_out),
        .busy            (busy),
        .gnt_id          (gnt_id)
    );

    // Core model: always has a word, value advances per output handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) seq <= '0;
        else if (!core_ready_in_n && core_valid_out) seq <= seq + 32'd1;
    end
    assign core_data_out = BASE + 64'(seq);

    // Back-pressure generator.
    initial begin
        int cyc;
        cyc = 0;
        rsp_ready      = '1;
        core_ready_out = 1'b1;
        core_valid_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (stall_mode) begin
                rsp_ready      = (cyc % 2 == 1) ? '1 : '0;
                core_ready_out = (cyc % 3) != 0;
                core_valid_out = (cyc % 4) != 1;
            end else begin
                rsp_ready      = '1;
                core_ready_out = 1'b1;
                core_valid_out = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic       pb;
        logic [0:0] pg;
        logic       regrant_due;
        int         who, cnt;
        xact_t      e;
        pb = 1'b0; pg = '0; regrant_due = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pb = 1'b0;
                regrant_due = 1'b0;
            end else begin
                // Input side transfer into the core.
                if (!core_valid_in_n && core_ready_out) begin
                    who = -1; cnt = 0;
                    for (int i = 0; i < N; i++) begin
                        if (req_ready[i] && req_valid[i]) begin who = i; cnt++; end
                    end
                    vectors++;
                    if (in_q.size() == 0) begin
                        $display("FAIL in_xfer: unexpected word %h from r%0d, required none", core_data_in, who);
                        miscompares++;
                    end else begin
                        e = in_q.pop_front();
                        if (cnt != 1 || who != int'(e.id) || core_data_in !== e.data) begin
                            $display("FAIL in_xfer: got r%0d (%0d ready) data %h, required r%0d data %h",
                                     who, cnt, core_data_in, e.id, e.data);
                            miscompares++;
                        end else begin
                            $display("in   r%0d data %h", who, core_data_in);
                        end
                    end
                end
                // Output side handshake to a requester.
                who = -1; cnt = 0;
                for (int i = 0; i < N; i++) begin
                    if (rsp_valid[i] && rsp_ready[i]) begin who = i; cnt++; end
                end
                if (cnt != 0) begin
                    vectors++;
                    if (out_q.size() == 0) begin
                        $display("FAIL out_xfer: unexpected word %h to r%0d, required none", rsp_data, who);
                        miscompares++;
                    end else begin
                        e = out_q.pop_front();
                        if (cnt != 1 || who != int'(e.id) || rsp_data !== e.data) begin
                            $display("FAIL out_xfer: got r%0d (%0d valid) data %h, required r%0d data %h",
                                     who, cnt, rsp_data, e.id, e.data);
                            miscompares++;
                        end else begin
                            $display("out  r%0d data %h", who, rsp_data);
                        end
                    end
                end
                // Routing invariants.
                if (!busy && (req_ready != '0 || rsp_valid != '0 || !core_valid_in_n || !core_ready_in_n)) begin
                    $display("FAIL idle_outputs: req_ready %b rsp_valid %b vin_n %b rin_n %b, required 0 0 1 1",
                             req_ready, rsp_valid, core_valid_in_n, core_ready_in_n);
                    miscompares++;
                end
                if (busy && (((req_ready | rsp_valid) & ~(N'(1) << gnt_id)) != '0)) begin
                    $display("FAIL non_owner: req_ready %b rsp_valid %b with owner %0d, required none to others",
                             req_ready, rsp_valid, gnt_id);
                    miscompares++;
                end
                if (pb && busy && gnt_id != pg) begin
                    $display("FAIL ownership: gnt_id %0d, required %0d held", gnt_id, pg);
                    miscompares++;
                end
                if (regrant_due) begin
                    vectors++;
                    if (!busy) begin
                        $display("FAIL regrant: busy %b one cycle after completion, required 1", busy);
                        miscompares++;
                    end
                end
                regrant_due = pb && !busy && (req_valid != '0);
                pb = busy;
                pg = gnt_id;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] msg_word(input rid_t r, input int j, input int i);
        return {8'(r), 8'(j), 16'hA5A5, 32'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, required %h", name, act, exp);
            miscompares++;
        end else begin
            $display("chk  %s = %h", name, act);
        end
    endtask

    // Queue the words a job should move, with hand-computed word counts.
    task automatic push_expect(input rid_t r, input int j, input logic [31:0] in_len,
                               input logic [31:0] out_len, input int nin, input int nout);
        in_q.push_back('{8'(r), {out_len, in_len}});
        for (int i = 0; i < nin; i++) in_q.push_back('{8'(r), msg_word(r, j, i)});
        for (int i = 0; i < nout; i++) begin
            out_q.push_back('{8'(r), BASE + 64'(exp_seq)});
            exp_seq++;
        end
    endtask

    task automatic send_word(input rid_t r, input logic [63:0] d, input bit gap);
        bit done;
        if (gap) begin
            rv[r] = 1'b0;
            @(posedge clk);
            #1;
        end
        rv[r] = 1'b1;
        rd[r] = d;
        done  = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL send_word: r%0d word %h never accepted, required acceptance", r, d);
        end
    endtask

    task automatic drive_job(input rid_t r, input int j, input logic [31:0] in_len,
                             input logic [31:0] out_len, input int nin, input bit stall);
        send_word(r, {out_len, in_len}, 1'b0);
        for (int i = 0; i < nin; i++) send_word(r, msg_word(r, j, i), stall);
        rv[r] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy && in_q.size() == 0 && out_q.size() == 0) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            $display("FAIL %s: busy %b, %0d inputs and %0d outputs outstanding, required idle and 0 0",
                     name, busy, in_q.size(), out_q.size());
            miscompares++;
            in_q.delete();
            out_q.delete();
        end else begin
            $display("done %s", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"},       64'(req_ready),       64'd0);
        chk({tag, ".rsp_valid"},       64'(rsp_valid),       64'd0);
        chk({tag, ".core_valid_in_n"}, 64'(core_valid_in_n), 64'd1);
        chk({tag, ".core_ready_in_n"}, 64'(core_ready_in_n), 64'd1);
        chk({tag, ".rsp_data"},        rsp_data,             64'd0);
        chk({tag, ".busy"},            64'(busy),            64'd0);
        chk({tag, ".gnt_id"},          64'(gnt_id),          64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin rv[i] = 1'b0; rd[i] = '0; end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters from reset: r0, then r1, then r0 again.
        push_expect(0, 1, 32'd128, 32'd64,  2, 1);
        push_expect(1, 2, 32'd64,  32'd128, 1, 2);
        push_expect(0, 3, 32'd0,   32'd0,   0, 1);
        fork
            begin
                drive_job(0, 1, 32'd128, 32'd64, 2, 1'b0);
                drive_job(0, 3, 32'd0,   32'd0,  0, 1'b0);
            end
            drive_job(1, 2, 32'd64, 32'd128, 1, 1'b0);
        join
        wait_idle("fairness");

        // Single job: no absorb, four squeeze words.
        push_expect(0, 4, 32'd0, 32'd256, 0, 4);
        drive_job(0, 4, 32'd0, 32'd256, 0, 1'b0);
        wait_idle("squeeze4");
        chk("squeeze4.busy", 64'(busy), 64'd0);

        // 17 absorb words, 2 squeeze words.
        push_expect(1, 5, 32'd1088, 32'd65, 17, 2);
        drive_job(1, 5, 32'd1088, 32'd65, 17, 1'b0);
        wait_idle("absorb17");

        // Stalls on both sides with the other requester waiting.
        stall_mode = 1'b1;
        push_expect(0, 6, 32'd192, 32'd200, 3, 4);
        push_expect(1, 7, 32'd64,  32'd64,  1, 1);
        fork
            drive_job(0, 6, 32'd192, 32'd200, 3, 1'b1);
            drive_job(1, 7, 32'd64,  32'd64,  1, 1'b1);
        join
        wait_idle("stalls");
        stall_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of ABSORB after 5 of 17 message words.
        in_q.push_back('{8'd0, {32'd64, 32'd1088}});
        for (int i = 0; i < 5; i++) in_q.push_back('{8'd0, msg_word(0, 8, i)});
        send_word(0, {32'd64, 32'd1088}, 1'b0);
        for (int i = 0; i < 5; i++) send_word(0, msg_word(0, 8, i), 1'b0);
        rst = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        chk("midjob_reset.inputs_seen", 64'(in_q.size()), 64'd0);
        rv[0] = 1'b0;
        in_q.delete();
        out_q.delete();
        exp_seq = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // After reset requester 0 has priority again.
        push_expect(0, 9,  32'd0, 32'd64, 0, 1);
        push_expect(1, 10, 32'd0, 32'd64, 0, 1);
        fork
            drive_job(0, 9,  32'd0, 32'd64, 0, 1'b0);
            drive_job(1, 10, 32'd0, 32'd64, 0, 1'b0);
        join
        wait_idle("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
